dram_arb: RTL



---
 rtl/dram_pkg.sv | 14 +
 rtl/dram_arb_sel.sv | 45 ++++
 rtl/dram_arb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM arbiter: client IDs and bus widths.
package dram_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        CL_NONE = 2'd0,
        CL_VID  = 2'd1,
        CL_CPU  = 2'd2,
        CL_DMA  = 2'd3
    } client_e;

endpackage

// File: rtl/dram_arb_sel.sv
// Priority / starvation decision for one DRAM cycle; the grant ID is held
// from the evaluation phase until the next evaluation.
module dram_arb_sel
    import dram_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_eval,
    input  logic    i_force_rfsh,
    input  logic    i_burst_hit,
    input  logic    i_vid_req,
    input  logic    i_cpu_req,
    input  logic    i_dma_req,
    output client_e o_sel,
    output client_e o_grant
);

    // Fixed priority: refresh slot, video, starved DMA, CPU, DMA.
    always_comb begin
        o_sel = CL_NONE;
        if (i_force_rfsh) begin
            o_sel = CL_NONE;
        end else if (i_vid_req) begin
            o_sel = CL_VID;
        end else if (i_dma_req && i_burst_hit) begin
            o_sel = CL_DMA;
        end else if (i_cpu_req) begin
            o_sel = CL_CPU;
        end else if (i_dma_req) begin
            o_sel = CL_DMA;
        end else begin
            o_sel = CL_NONE;
        end
    end

    // Hold the decision for the rest of the DRAM cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_grant <= CL_NONE;
        end else if (i_eval) begin
            o_grant <= o_sel;
        end
    end

endmodule

// File: rtl/dram_arb.sv
// Three-client arbiter in front of the 4-phase DRAM controller: one access
// per DRAM cycle, forced refresh slots, CPU burst limit, read data return.
module dram_arb
    import dram_pkg::*;
#(
    parameter int RFSH_PERIOD = 64,
    parameter int CPU_BURST   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0,
    input  logic              c1,
    input  logic              c2,
    input  logic              c3,
    input  logic              vid_req,
    input  logic              cpu_req,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              cpu_rnw,
    input  logic              dma_rnw,
    input  logic [1:0]        cpu_bsel,
    input  logic [1:0]        dma_bsel,
    input  logic [DATA_W-1:0] cpu_wd,
    input  logic [DATA_W-1:0] dma_wd,
    output logic              vid_next,
    output logic              cpu_next,
    output logic              dma_next,
    output logic              vid_strb,
    output logic              cpu_strb,
    output logic              dma_strb,
    output logic [DATA_W-1:0] rddata,
    output logic              drm_req,
    output logic              drm_rnw,
    output logic [ADDR_W-1:0] drm_addr,
    output logic [1:0]        drm_bsel,
    output logic [DATA_W-1:0] drm_wd,
    input  logic [DATA_W-1:0] drm_rd
);

    localparam logic [7:0] RFSH_LAST = 8'(RFSH_PERIOD - 1);
    localparam logic [3:0] CPU_MAX   = 4'(CPU_BURST);

    logic       w_c2;
    logic       w_c3;
    logic       w_if_read;
    client_e    w_sel;
    client_e    w_grant;
    logic [7:0] r_rfsh_cnt;
    logic [3:0] r_cpu_run;
    client_e    r_if_owner;
    logic       r_if_rd;

    // Act only on a clean one-hot phase so a glitched decode cannot grant twice.
    assign w_c2      = c2 & ~(c0 | c1 | c3);
    assign w_c3      = c3 & ~(c0 | c1 | c2);
    assign w_if_read = r_if_rd && (r_if_owner != CL_NONE);

    dram_arb_sel u_sel (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_eval       (w_c2),
        .i_force_rfsh (r_rfsh_cnt == RFSH_LAST),
        .i_burst_hit  (r_cpu_run == CPU_MAX),
        .i_vid_req    (vid_req),
        .i_cpu_req    (cpu_req),
        .i_dma_req    (dma_req),
        .o_sel        (w_sel),
        .o_grant      (w_grant)
    );

    // Request port to the controller, registered at c2 with the grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drm_req  <= 1'b0;
            drm_rnw  <= 1'b1;
            drm_addr <= '0;
            drm_bsel <= 2'b00;
        end else if (w_c2) begin
            drm_req <= (w_sel != CL_NONE);
            case (w_sel)
                CL_VID: begin
                    drm_addr <= vid_addr;
                    drm_rnw  <= 1'b1;
                    drm_bsel <= 2'b11;
                end
                CL_CPU: begin
                    drm_addr <= cpu_addr;
                    drm_rnw  <= cpu_rnw;
                    drm_bsel <= cpu_bsel;
                end
                CL_DMA: begin
                    drm_addr <= dma_addr;
                    drm_rnw  <= dma_rnw;
                    drm_bsel <= dma_bsel;
                end
                default: begin
                    drm_addr <= '0;
                    drm_rnw  <= 1'b1;
                    drm_bsel <= 2'b00;
                end
            endcase
        end
    end

    // Refresh spacing and CPU burst counters, both stepped once per DRAM cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rfsh_cnt <= 8'd0;
            r_cpu_run  <= 4'd0;
        end else if (w_c2) begin
            r_rfsh_cnt <= (w_sel == CL_NONE) ? 8'd0 : r_rfsh_cnt + 8'd1;
            if ((w_sel == CL_DMA) || !dma_req) begin
                r_cpu_run <= 4'd0;
            end else if ((w_sel == CL_CPU) && (r_cpu_run != CPU_MAX)) begin
                r_cpu_run <= r_cpu_run + 4'd1;
            end
        end
    end

    // Accept pulses and read-return strobes: set at c2, live for the c3 clk only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {vid_next, cpu_next, dma_next} <= 3'b000;
            {vid_strb, cpu_strb, dma_strb} <= 3'b000;
            rddata                         <= '0;
        end else if (w_c2) begin
            vid_next <= (w_sel == CL_VID);
            cpu_next <= (w_sel == CL_CPU);
            dma_next <= (w_sel == CL_DMA);
            vid_strb <= w_if_read && (r_if_owner == CL_VID);
            cpu_strb <= w_if_read && (r_if_owner == CL_CPU);
            dma_strb <= w_if_read && (r_if_owner == CL_DMA);
            if (w_if_read) begin
                rddata <= drm_rd;
            end
        end else begin
            {vid_next, cpu_next, dma_next} <= 3'b000;
            {vid_strb, cpu_strb, dma_strb} <= 3'b000;
        end
    end

    // In-flight tracker and write data, taken at c3 from the held grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_if_owner <= CL_NONE;
            r_if_rd    <= 1'b0;
            drm_wd     <= '0;
        end else if (w_c3) begin
            r_if_owner <= w_grant;
            r_if_rd    <= drm_rnw;
            case (w_grant)
                CL_CPU:  drm_wd <= cpu_wd;
                CL_DMA:  drm_wd <= dma_wd;
                default: drm_wd <= drm_wd;
            endcase
        end
    end

endmodule
